writeback_queue: RTL and testbench

Multi-lane, buffered successor to the single-lane writeback stage. It accepts up to `LANES` retiring results per cycle from the memory stage and queues them in order in a `DEPTH`-entry FIFO. It drains one register-file write per cycle, keeps a retired-instruction counter, and raises a sticky halt once the final instruction has been written back. It sits between the memory stage and the register file's single write port.

---
 rtl/writeback_queue.sv | 138 +++++++++++++
 tb/tb_writeback_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// writeback_queue: multi-lane in-order result queue feeding the register file's single write port.
// Latency: a result accepted at edge N is presented on the write port in the following cycle if it is at the head.
// Backpressure: in_ready drops when fewer than LANES slots are free (a same-cycle pop is not credited) or once halted.
// Optional trace output: define WRITEBACK_TRACE_EN.
module writeback_queue #(
  parameter int XLEN  = 32,
  parameter int LANES = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES*5-1:0]         in_rd,
  input  logic [LANES*XLEN-1:0]      in_data,
  input  logic [LANES-1:0]           in_reg_write,
  input  logic [LANES-1:0]           in_is_final,
  input  logic [LANES-1:0]           in_instr_done,
  output logic                       in_ready,
  output logic [4:0]                 writeback_address,
  output logic [XLEN-1:0]            write_back_data,
  output logic                       write_back_enable,
  output logic [31:0]                retired_count,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            reg_write;
    logic            is_final;
    logic            instr_done;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [OW-1:0]   occ_q;
  logic [31:0]     retired_q;
  logic            halted_q;

  logic [AW-1:0]   lane_idx [LANES];
  logic [OW-1:0]   push_cnt;
  logic            accept;
  logic            pop;
  entry_t          head;

  // Admission only looks at registered occupancy, so a pop in the same cycle never opens room early.
  assign in_ready = !halted_q && ((int'(occ_q) + LANES) <= DEPTH);
  assign accept   = in_ready && (|in_valid);
  assign pop      = (occ_q != '0) && !halted_q;
  assign head     = mem[rd_ptr];

  // Pack valid lanes densely in lane order: each valid lane lands at wr_ptr plus the number of older valid lanes.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_idx[i] = wr_ptr + AW'(push_cnt);
      if (in_valid[i]) begin
        push_cnt = push_cnt + OW'(1);
      end
    end
  end

  // Payload storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (accept && in_valid[i]) begin
        mem[lane_idx[i]] <= '{rd:         in_rd[5*i +: 5],
                              data:       in_data[XLEN*i +: XLEN],
                              reg_write:  in_reg_write[i],
                              is_final:   in_is_final[i],
                              instr_done: in_instr_done[i]};
      end
    end
  end

  // Pointers, occupancy, retire counter and the sticky halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ_q     <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(push_cnt);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        if (head.instr_done) begin
          retired_q <= retired_q + 32'd1;
        end
        if (head.is_final) begin
          halted_q <= 1'b1;
        end
      end
      occ_q <= occ_q + (accept ? push_cnt : OW'(0)) - (pop ? OW'(1) : OW'(0));
    end
  end

  // Write port is driven straight from the head; x0 writes are dropped but the entry still retires.
  always_comb begin
    write_back_enable = 1'b0;
    writeback_address = 5'd0;
    write_back_data   = '0;
    if (pop) begin
      write_back_enable = head.reg_write && (head.rd != 5'd0);
      writeback_address = head.rd;
      write_back_data   = head.data;
    end
  end

  assign retired_count = retired_q;
  assign occupancy     = occ_q;
  assign halted        = halted_q;

`ifdef WRITEBACK_TRACE_EN
  // Simulation trace of every pop and of the halt event.
  always @(posedge clk) begin
    if (!rst && pop) begin
      $display("%0t wb: addr=x%0d data=%h en=%0b final=%0b done=%0b retired=%0d",
               $time, head.rd, head.data, write_back_enable, head.is_final,
               head.instr_done, retired_q);
      if (head.is_final) begin
        $display("%0t wb: halted, final retired=%0d", $time,
                 retired_q + (head.instr_done ? 32'd1 : 32'd0));
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue: directed groups, scoreboard of expected register writes.
// Expected writes are queued when a group is driven; a negedge monitor pops and compares.
module tb_writeback_queue;

  localparam int XLEN  = 32;
  localparam int LANES = 2;
  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [LANES-1:0]      in_valid;
  logic [LANES*5-1:0]    in_rd;
  logic [LANES*XLEN-1:0] in_data;
  logic [LANES-1:0]      in_reg_write;
  logic [LANES-1:0]      in_is_final;
  logic [LANES-1:0]      in_instr_done;
  logic                  in_ready;
  logic [4:0]            writeback_address;
  logic [XLEN-1:0]       write_back_data;
  logic                  write_back_enable;
  logic [31:0]           retired_count;
  logic [$clog2(DEPTH):0] occupancy;
  logic                  halted;

  writeback_queue #(.XLEN(XLEN), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_rd             (in_rd),
    .in_data           (in_data),
    .in_reg_write      (in_reg_write),
    .in_is_final       (in_is_final),
    .in_instr_done     (in_instr_done),
    .in_ready          (in_ready),
    .writeback_address (writeback_address),
    .write_back_data   (write_back_data),
    .write_back_enable (write_back_enable),
    .retired_count     (retired_count),
    .occupancy         (occupancy),
    .halted            (halted)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned exp_ret  = 0;
  logic [36:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && write_back_enable) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got x%0d=%h expected no write",
                 writeback_address, write_back_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("write", {27'd0, writeback_address, write_back_data}, {27'd0, e});
      end
    end
  end

  // Drive one group (called at posedge+1); returns at posedge+1 after the accepting edge.
  task automatic drive_group(input logic [1:0] v, input logic [4:0] rd0, input logic [4:0] rd1,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [1:0] rw, input logic [1:0] fin,
                             input logic [1:0] done, input bit track);
    int waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("push_timeout_in_ready", {63'd0, in_ready}, 64'd1);
      return;
    end
    in_valid      = v;
    in_rd         = {rd1, rd0};
    in_data       = {d1, d0};
    in_reg_write  = rw;
    in_is_final   = fin;
    in_instr_done = done;
    if (track) begin
      if (v[0] && rw[0] && rd0 != 5'd0) exp_q.push_back({rd0, d0});
      if (v[1] && rw[1] && rd1 != 5'd0) exp_q.push_back({rd1, d1});
      if (v[0] && done[0]) exp_ret++;
      if (v[1] && done[1]) exp_ret++;
    end
    @(posedge clk); #1;
    in_valid = '0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (occupancy != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_occupancy", 64'(occupancy), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0; in_rd = '0; in_data = '0;
    in_reg_write = '0; in_is_final = '0; in_instr_done = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_wb_enable", 64'(write_back_enable), 64'd0);
    check("rst_retired", 64'(retired_count), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Ordering: x5 then x6, occupancy 2 -> 1 -> 0
    drive_group(2'b11, 5'd5, 5'd6, 32'hAAAA, 32'hBBBB, 2'b11, 2'b00, 2'b11, 1);
    check("order_occ2", 64'(occupancy), 64'd2);
    @(posedge clk); #1;
    check("order_occ1", 64'(occupancy), 64'd1);
    @(posedge clk); #1;
    check("order_occ0", 64'(occupancy), 64'd0);
    check("order_retired", 64'(retired_count), 64'(exp_ret));

    // x0 suppression: popped and retired, no write strobe
    drive_group(2'b01, 5'd0, 5'd0, 32'h55, 32'h0, 2'b01, 2'b00, 2'b01, 1);
    check("x0_occ1", 64'(occupancy), 64'd1);
    @(posedge clk); #1;
    check("x0_occ0", 64'(occupancy), 64'd0);
    check("x0_retired", 64'(retired_count), 64'(exp_ret));

    // Partial lanes: only lane 1 valid
    drive_group(2'b10, 5'd9, 5'd7, 32'hDEAD, 32'h1234, 2'b11, 2'b00, 2'b11, 1);
    check("partial_occ1", 64'(occupancy), 64'd1);
    @(posedge clk); #1;
    check("partial_occ0", 64'(occupancy), 64'd0);
    check("partial_retired", 64'(retired_count), 64'(exp_ret));

    // Backpressure: two back-to-back groups -> occupancy 3, in_ready low
    drive_group(2'b11, 5'd10, 5'd11, 32'h1010, 32'h1111, 2'b11, 2'b00, 2'b11, 1);
    drive_group(2'b11, 5'd12, 5'd13, 32'h1212, 32'h1313, 2'b11, 2'b00, 2'b11, 1);
    check("bp_occ3", 64'(occupancy), 64'd3);
    check("bp_in_ready", 64'(in_ready), 64'd0);

    // Streaming with gaps across pointer wrap
    for (int k = 0; k < 20; k++) begin
      int gap;
      logic [1:0] v;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      v = (k % 5 == 3) ? 2'b10 : 2'b11;
      drive_group(v, 5'(1 + (2*k) % 31), 5'(1 + (2*k + 1) % 31),
                  32'hC000_0000 + 32'(2*k), 32'hC000_0000 + 32'(2*k + 1),
                  2'b11, 2'b00, 2'b11, 1);
    end
    wait_empty();
    check("stream_retired", 64'(retired_count), 64'(exp_ret));

    // Reset mid-stream with 3 entries queued
    drive_group(2'b11, 5'd14, 5'd15, 32'h1414, 32'h1515, 2'b11, 2'b00, 2'b11, 1);
    drive_group(2'b11, 5'd16, 5'd17, 32'h1616, 32'h1717, 2'b11, 2'b00, 2'b11, 1);
    check("pre_rst_occ3", 64'(occupancy), 64'd3);
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_ret = 0;
    check("mid_rst_occupancy", 64'(occupancy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_wb", {27'd0, write_back_enable, writeback_address, write_back_data}, 64'd0);
    check("mid_rst_retired", 64'(retired_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_occupancy", 64'(occupancy), 64'd0);

    // Halt: x1, x2(final) written; x3 frozen in the queue
    drive_group(2'b11, 5'd1, 5'd2, 32'h11, 32'h22, 2'b11, 2'b10, 2'b11, 1);
    drive_group(2'b01, 5'd3, 5'd0, 32'h33, 32'h0, 2'b01, 2'b00, 2'b01, 0);
    @(posedge clk); #1;
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_retired", 64'(retired_count), 64'd2);
    check("halt_in_ready", 64'(in_ready), 64'd0);
    check("halt_occ", 64'(occupancy), 64'd1);
    repeat (4) begin @(posedge clk); #1; end
    check("halt_sticky", 64'(halted), 64'd1);
    check("halt_frozen_occ", 64'(occupancy), 64'd1);
    check("halt_no_write", 64'(write_back_enable), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
